ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
- Receive-side PS/2 keyboard interface for the Breakout game. It is the input counterpart to the VGA/7-segment output path.
- Deserialises device-clocked PS/2 frames into scan codes and tracks make/break prefixes.
- Drives held-key levels for left arrow, right arrow and space. These replace the KEY pushbuttons on move_bar and the start switch on move_ball/placar.
- Runs on the 25 MHz VGA_CLK domain.

Parameters:
- FILTER_LEN, 4: number of consecutive equal synchronised ps2_clk samples required before the filtered level changes.
- TIMEOUT_CYCLES, 50000: idle clock cycles allowed between falling edges inside a frame before abort (2 ms at 25 MHz).

Ports:
- clock  input  1  system clock (VGA_CLK).
- reset  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock, asynchronous to clock.
- ps2_data  input  1  raw PS/2 data, asynchronous to clock.
- scan_code  output  8  last accepted non-prefix byte.
- code_valid  output  1  one-cycle pulse; scan_code, is_break and is_extended are valid.
- is_break  output  1  accepted byte was preceded by F0.
- is_extended  output  1  accepted byte was preceded by E0.
- frame_err  output  1  one-cycle pulse on parity, stop or timeout error.
- key_left  output  1  level; E0 6B held.
- key_right  output  1  level; E0 74 held.
- key_space  output  1  level; 29 held.

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM in IDLE, bit count 0, pendings cleared, filtered clock = 1, filter history all 1, timeout counter 0. Reset dominates every other event.
- Input conditioning:
  - 2-FF synchronisers on ps2_clk and ps2_data.
  - Filter: the filtered clock becomes v only after FILTER_LEN consecutive synced samples equal v; otherwise it holds.
  - A falling edge (fe) is a single-cycle strobe when the filtered clock goes 1->0. Data is sampled from the synced ps2_data on the fe cycle.
- FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: on fe with data=0, go to DATA with bit count 0. On fe with data=1, stay (glitch/noise is ignored with no error).
  - DATA: on each fe, shift right with the data bit inserted at bit 7 (LSB first). After the 8th bit, go to PARITY.
  - PARITY: on fe, latch the parity bit and go to STOP.
  - STOP: on fe, go to IDLE.
    - Frame OK if stop=1 and XOR(8 data bits, parity) = 1 (odd parity).
    - If not OK: frame_err pulses on the next cycle.
- Timeout:
  - Counter runs in DATA, PARITY and STOP; it clears on every fe and in IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_err, clear pendings.
- Byte handling for an OK frame:
  - E0: set ext_pending. No code_valid.
  - F0: set brk_pending. No code_valid.
  - Any other byte:
    - scan_code <= byte; is_break <= brk_pending; is_extended <= ext_pending; code_valid pulses.
    - Both pendings clear.
    - E0 6B updates key_left <= ~brk_pending. E0 74 updates key_right <= ~brk_pending. Non-extended 29 updates key_space <= ~brk_pending.
    - Other codes do not touch the key levels.
- Any frame error clears both pendings. The key levels hold.
- Latency: code_valid or frame_err is asserted exactly 1 cycle after the fe of the stop bit. From the raw ps2_clk fall this is at most FILTER_LEN+4 cycles.
- code_valid and frame_err are never asserted together. Both are registered pulses exactly one cycle wide.
- scan_code, is_break and is_extended hold between pulses.
- Prefix order is free: F0 then E0, or E0 then F0, both yield is_break=is_extended=1.

Test Plan:
- Reset state: reset=0 mid-frame (after 4 data bits), then release -> all outputs 0, FSM IDLE. A following clean frame 0x1C (parity 0) -> code_valid, scan_code=0x1C, is_break=0, is_extended=0.
- Arrow key make/break: frames E0(p0), 6B(p0) -> one code_valid, is_extended=1, key_left=1. Then E0, F0(p1), 6B -> is_break=1, key_left=0. key_right and key_space stay 0 throughout.
- Space and right arrow held together: 29(p0), then E0, 74(p1) -> key_space=1, key_right=1. Then F0, 29 -> key_space=0, key_right still 1.
- Parity error: 0x29 sent with parity 1 -> frame_err single pulse, no code_valid, key_space unchanged. The next E0 prefix is unaffected by the earlier error.
- Stop-bit error and timeout:
  - 0x1C with stop=0 -> frame_err pulse.
  - Separately, stop ps2_clk after 3 data bits -> frame_err exactly TIMEOUT_CYCLES cycles after the last fe, FSM IDLE.
  - A pending F0 is discarded, so a following 29 gives is_break=0.
- Glitch rejection: ps2_clk low pulse of FILTER_LEN-1 cycles while IDLE, with data=0 -> no state change. A pulse of FILTER_LEN+1 cycles -> accepted as a start bit.

Source files
------------

// File: rtl/ps2_keyboard_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : ps2_keyboard_rx_if
// Description : Bundle of raw PS/2 lines and decoded keyboard outputs.
//               master = receiver side, slave = line driver / consumer side.
// Revision    : 1.0 - initial release
//==============================================================================
interface ps2_keyboard_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] scan_code;
   logic       code_valid;
   logic       is_break;
   logic       is_extended;
   logic       frame_err;
   logic       key_left;
   logic       key_right;
   logic       key_space;

   modport master (
      input  ps2_clk, ps2_data,
      output scan_code, code_valid, is_break, is_extended, frame_err,
             key_left, key_right, key_space
   );

   modport slave (
      output ps2_clk, ps2_data,
      input  scan_code, code_valid, is_break, is_extended, frame_err,
             key_left, key_right, key_space
   );
endinterface
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : ps2_keyboard_rx
// Description : PS/2 keyboard receiver. Synchronises and filters the device
//               clock, deserialises 11-bit frames, tracks E0/F0 prefixes and
//               drives held-key levels for left, right and space.
// Revision    : 1.0 - initial release
//==============================================================================
module ps2_keyboard_rx #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  wire logic          clock,
   input  wire logic          reset,
   ps2_keyboard_rx_if.master  bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Input conditioning
   logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic [FILTER_LEN-1:0] hist_q, hist_d;
   logic                  filt_q, filt_d;
   logic                  fe;

   // Frame and decode state
   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       par_q, par_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic       ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
   logic [7:0] scan_code_q, scan_code_d;
   logic       code_valid_q, code_valid_d, frame_err_q, frame_err_d;
   logic       is_break_q, is_break_d, is_ext_q, is_ext_d;
   logic       key_left_q, key_left_d, key_right_q, key_right_d;
   logic       key_space_q, key_space_d;

   // Filter: level flips only once the whole history window agrees
   always_comb begin
      hist_d = {hist_q[FILTER_LEN-2:0], clk_s2_q};
      filt_d = filt_q;
      if (&hist_d)
         filt_d = 1'b1;
      else if (~|hist_d)
         filt_d = 1'b0;
      fe = filt_q & ~filt_d;
   end

   // Synchronisers and filter registers; idle PS/2 lines are high
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         hist_q   <= '1;
         filt_q   <= 1'b1;
      end else begin
         clk_s1_q <= bus.ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= bus.ps2_data;
         dat_s2_q <= dat_s1_q;
         hist_q   <= hist_d;
         filt_q   <= filt_d;
      end
   end

   // Frame FSM, timeout, prefix tracking and key-level decode
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      cnt_d        = cnt_q;
      ext_pend_d   = ext_pend_q;
      brk_pend_d   = brk_pend_q;
      scan_code_d  = scan_code_q;
      is_break_d   = is_break_q;
      is_ext_d     = is_ext_q;
      key_left_d   = key_left_q;
      key_right_d  = key_right_q;
      key_space_d  = key_space_q;
      code_valid_d = 1'b0;
      frame_err_d  = 1'b0;

      if (state_q == IDLE) begin
         cnt_d = '0;
         // A high data line on a falling edge is noise, not a start bit
         if (fe && !dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
         end
      end else if (fe) begin
         cnt_d = '0;
         case (state_q)
            DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7)
                  state_d = PARITY;
            end
            PARITY: begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end
            default: begin
               state_d = IDLE;
               if (dat_s2_q && ((^shift_q) ^ par_q)) begin
                  if (shift_q == 8'hE0) begin
                     ext_pend_d = 1'b1;
                  end else if (shift_q == 8'hF0) begin
                     brk_pend_d = 1'b1;
                  end else begin
                     scan_code_d  = shift_q;
                     is_break_d   = brk_pend_q;
                     is_ext_d     = ext_pend_q;
                     code_valid_d = 1'b1;
                     ext_pend_d   = 1'b0;
                     brk_pend_d   = 1'b0;
                     if (ext_pend_q && shift_q == 8'h6B)
                        key_left_d = ~brk_pend_q;
                     if (ext_pend_q && shift_q == 8'h74)
                        key_right_d = ~brk_pend_q;
                     if (!ext_pend_q && shift_q == 8'h29)
                        key_space_d = ~brk_pend_q;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  ext_pend_d  = 1'b0;
                  brk_pend_d  = 1'b0;
               end
            end
         endcase
      end else if (cnt_q == c_to_last) begin
         // Device stopped clocking mid-frame: abandon it
         state_d     = IDLE;
         cnt_d       = '0;
         frame_err_d = 1'b1;
         ext_pend_d  = 1'b0;
         brk_pend_d  = 1'b0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State register for the frame FSM and decoded outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         par_q        <= 1'b0;
         cnt_q        <= '0;
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         scan_code_q  <= 8'h00;
         is_break_q   <= 1'b0;
         is_ext_q     <= 1'b0;
         key_left_q   <= 1'b0;
         key_right_q  <= 1'b0;
         key_space_q  <= 1'b0;
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         cnt_q        <= cnt_d;
         ext_pend_q   <= ext_pend_d;
         brk_pend_q   <= brk_pend_d;
         scan_code_q  <= scan_code_d;
         is_break_q   <= is_break_d;
         is_ext_q     <= is_ext_d;
         key_left_q   <= key_left_d;
         key_right_q  <= key_right_d;
         key_space_q  <= key_space_d;
         code_valid_q <= code_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign bus.scan_code   = scan_code_q;
   assign bus.code_valid  = code_valid_q;
   assign bus.is_break    = is_break_q;
   assign bus.is_extended = is_ext_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.key_left    = key_left_q;
   assign bus.key_right   = key_right_q;
   assign bus.key_space   = key_space_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_ps2_keyboard_rx
// Description : Self-checking bench for ps2_keyboard_rx: directed frames from
//               the test plan followed by random byte streams, compared
//               against a byte-level keyboard model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ps2_keyboard_rx;

   localparam int FL = 4;
   localparam int TO = 200;
   localparam int H  = 8;    // PS/2 half period in system clocks

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ps2_keyboard_rx_if bus();

   ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Free-running cycle count and pulse tallies sampled on the quiet edge
   int cyc = 0;
   int n_cv = 0, n_err = 0, n_both = 0, last_pulse = 0;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) begin
      if (bus.code_valid) n_cv <= n_cv + 1;
      if (bus.frame_err) n_err <= n_err + 1;
      if (bus.code_valid && bus.frame_err) n_both <= n_both + 1;
      if (bus.code_valid || bus.frame_err) last_pulse <= cyc;
   end

   // Keyboard model state
   logic       m_ext = 0, m_brk = 0;
   logic       m_left = 0, m_right = 0, m_space = 0;
   logic [7:0] m_scan = 0;
   logic       m_isbrk = 0, m_isext = 0;
   int         e_cv = 0, e_err = 0;
   int         fall_cyc = 0;

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clk_bit(input logic d);
      bus.ps2_data = d;
      wait_cyc(H/2);
      bus.ps2_clk = 1'b0;
      fall_cyc = cyc;
      wait_cyc(H);
      bus.ps2_clk = 1'b1;
      wait_cyc(H/2);
   endtask

   // Byte-level view of a keyboard: prefixes accumulate, anything else reports
   task automatic model_byte(input logic [7:0] b, input bit bad);
      if (bad) begin
         e_err++;
         m_ext = 0;
         m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         e_cv++;
         m_scan  = b;
         m_isbrk = m_brk;
         m_isext = m_ext;
         if (m_ext && b == 8'h6B) m_left  = !m_brk;
         if (m_ext && b == 8'h74) m_right = !m_brk;
         if (!m_ext && b == 8'h29) m_space = !m_brk;
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".cv_count"},  n_cv, e_cv);
      chk({tag, ".err_count"}, n_err, e_err);
      chk({tag, ".scan"},      bus.scan_code, m_scan);
      chk({tag, ".is_break"},  bus.is_break, m_isbrk);
      chk({tag, ".is_ext"},    bus.is_extended, m_isext);
      chk({tag, ".key_left"},  bus.key_left, m_left);
      chk({tag, ".key_right"}, bus.key_right, m_right);
      chk({tag, ".key_space"}, bus.key_space, m_space);
      chk({tag, ".both"},      n_both, 0);
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   task automatic send(input string tag, input logic [7:0] b, input bit bp, input bit bs);
      logic [10:0] fr;
      bit pulse;
      fr = mk(b, bp, bs);
      for (int i = 0; i < 11; i++) clk_bit(fr[i]);
      bus.ps2_data = 1'b1;
      wait_cyc(12);
      pulse = bp || bs || !(b == 8'hE0 || b == 8'hF0);
      model_byte(b, bp || bs);
      check_all(tag);
      if (pulse)
         chk({tag, ".latency_ok"},
             32'((last_pulse - fall_cyc >= 1) && (last_pulse - fall_cyc <= FL + 4)), 1);
   endtask

   initial begin
      logic [10:0] fr;
      int t0;
      bit got;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      wait_cyc(5);
      reset = 1'b1;
      wait_cyc(10);
      check_all("reset0");

      // Put something in the outputs, then reset in the middle of a frame
      send("pre29", 8'h29, 0, 0);
      fr = mk(8'h1C, 0, 0);
      for (int i = 0; i < 5; i++) clk_bit(fr[i]);
      reset = 1'b0;
      #1;
      chk("rst.scan",  bus.scan_code, 0);
      chk("rst.space", bus.key_space, 0);
      chk("rst.cv",    bus.code_valid, 0);
      chk("rst.err",   bus.frame_err, 0);
      chk("rst.brk",   bus.is_break, 0);
      m_ext = 0; m_brk = 0; m_left = 0; m_right = 0; m_space = 0;
      m_scan = 0; m_isbrk = 0; m_isext = 0;
      bus.ps2_clk = 1'b1;
      bus.ps2_data = 1'b1;
      wait_cyc(3);
      reset = 1'b1;
      wait_cyc(10);
      send("clean1C", 8'h1C, 0, 0);

      // Left arrow make then break
      send("l.e0", 8'hE0, 0, 0);
      send("l.6b", 8'h6B, 0, 0);
      send("lb.e0", 8'hE0, 0, 0);
      send("lb.f0", 8'hF0, 0, 0);
      send("lb.6b", 8'h6B, 0, 0);

      // Space and right arrow held together, then release space
      send("s.29", 8'h29, 0, 0);
      send("r.e0", 8'hE0, 0, 0);
      send("r.74", 8'h74, 0, 0);
      send("sb.f0", 8'hF0, 0, 0);
      send("sb.29", 8'h29, 0, 0);

      // Parity error, then a prefix that must still work
      send("perr.29", 8'h29, 1, 0);
      send("pe.e0", 8'hE0, 0, 0);
      send("pe.6b", 8'h6B, 0, 0);

      // Stop-bit error
      send("serr.1c", 8'h1C, 0, 1);

      // Timeout with a pending F0 that must be dropped
      send("to.f0", 8'hF0, 0, 0);
      fr = mk(8'h29, 0, 0);
      for (int i = 0; i < 4; i++) clk_bit(fr[i]);
      bus.ps2_data = 1'b1;
      t0 = fall_cyc;
      got = 0;
      for (int k = 0; k < TO + FL + 20; k++) begin
         @(negedge clock);
         if (bus.frame_err) begin
            got = 1;
            break;
         end
      end
      chk("to.seen", 32'(got), 1);
      chk("to.delay_ok", 32'((cyc - t0 >= TO) && (cyc - t0 <= TO + FL + 4)), 1);
      wait_cyc(5);
      model_byte(8'h00, 1);
      check_all("to");
      send("to.29", 8'h29, 0, 0);

      // Short glitch while idle is ignored; a following frame decodes normally
      bus.ps2_data = 1'b0;
      bus.ps2_clk  = 1'b0;
      wait_cyc(FL - 1);
      bus.ps2_clk  = 1'b1;
      wait_cyc(20);
      bus.ps2_data = 1'b1;
      wait_cyc(5);
      check_all("glitch_short");
      send("gs.1c", 8'h1C, 0, 0);

      // A slightly longer low pulse counts as the start bit
      fr = mk(8'h5A, 0, 0);
      bus.ps2_data = 1'b0;
      bus.ps2_clk  = 1'b0;
      wait_cyc(FL + 1);
      bus.ps2_clk  = 1'b1;
      wait_cyc(H/2);
      for (int i = 1; i < 11; i++) clk_bit(fr[i]);
      bus.ps2_data = 1'b1;
      wait_cyc(12);
      model_byte(8'h5A, 0);
      check_all("glitch_long");

      // Random byte stream with occasional parity/stop faults
      for (int n = 0; n < 40; n++) begin
         logic [7:0] b;
         bit bp, bs;
         case ($urandom_range(0, 7))
            0: b = 8'hE0;
            1: b = 8'hF0;
            2: b = 8'h6B;
            3: b = 8'h74;
            4: b = 8'h29;
            default: b = 8'($urandom);
         endcase
         bp = ($urandom_range(0, 9) == 0);
         bs = ($urandom_range(0, 19) == 0);
         send("rnd", b, bp, bs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
